// File: rtl/cmul_mul_sequencer_if.sv
// Handshake/bus bundle for cmul_mul_sequencer.
// Three groups of signals:
//   - operand set from the FFT stage controller
//   - operand/result path to the shared FP16 multiplier
//   - partial products to the downstream add/sub stage
// The in_conj port exists only when CMUL_CONJ_EN is defined.
// The master modport is the sequencer's view; slave is the environment's view.
interface cmul_mul_sequencer_if #(
  parameter int DW = 16
);
  // Operand set from the stage controller
  logic          in_vld;
  logic          in_rdy;
  logic [DW-1:0] in_ar;
  logic [DW-1:0] in_ai;
  logic [DW-1:0] in_wr;
  logic [DW-1:0] in_wi;
`ifdef CMUL_CONJ_EN
  logic          in_conj;
`endif

  // Shared multiplier
  logic [DW-1:0] mul_a;
  logic [DW-1:0] mul_b;
  logic          mul_vld;
  logic [DW-1:0] mul_res;
  logic          mul_res_vld;
  logic          mul_exception;
  logic          mul_overflow;
  logic          mul_underflow;

  // Partial products to the add/sub stage
  logic [DW-1:0] out_rr;
  logic [DW-1:0] out_ii;
  logic [DW-1:0] out_ri;
  logic [DW-1:0] out_ir;
  logic          out_exc;
  logic          out_ovf;
  logic          out_unf;
  logic          out_vld;
  logic          out_rdy;

  modport master (
`ifdef CMUL_CONJ_EN
    input  in_conj,
`endif
    input  in_vld, in_ar, in_ai, in_wr, in_wi,
    output in_rdy,
    output mul_a, mul_b, mul_vld,
    input  mul_res, mul_res_vld, mul_exception, mul_overflow, mul_underflow,
    output out_rr, out_ii, out_ri, out_ir, out_exc, out_ovf, out_unf, out_vld,
    input  out_rdy
  );

  modport slave (
`ifdef CMUL_CONJ_EN
    output in_conj,
`endif
    output in_vld, in_ar, in_ai, in_wr, in_wi,
    input  in_rdy,
    input  mul_a, mul_b, mul_vld,
    output mul_res, mul_res_vld, mul_exception, mul_overflow, mul_underflow,
    input  out_rr, out_ii, out_ri, out_ir, out_exc, out_ovf, out_unf, out_vld,
    output out_rdy
  );
endinterface

// File: rtl/cmul_mul_sequencer.sv
// cmul_mul_sequencer: time-multiplexes one FP16 multiplier across the four
// real products of a complex twiddle multiply (a_r + j*a_i)*(w_r + j*w_i).
//
// Issue order is rr, ii, ri, ir. Results are collected in return order,
// however many cycles the multiplier takes. The three multiplier flags are
// OR-ed over the four products. The block does no arithmetic itself.
//
// Optional feature macro: CMUL_CONJ_EN. When defined, in_conj flips the
// sign bit of w_i at accept, which conjugates the twiddle for the IFFT.
module cmul_mul_sequencer #(
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cmul_mul_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t        state;
  logic [1:0]    issue_cnt;
  logic [2:0]    ret_cnt;    // [2] = all four returned, [1:0] = next slot
  logic [DW-1:0] ar_q, ai_q, wr_q, wi_q;
  logic [DW-1:0] wi_eff;
  logic          capture;

  logic          in_rdy_q;
  logic          mul_vld_q;
  logic [DW-1:0] mul_a_q, mul_b_q;
  logic [DW-1:0] rr_q, ii_q, ri_q, ir_q;
  logic          exc_q, ovf_q, unf_q;
  logic          out_vld_q;

  // Twiddle imaginary part as it will be stored (optionally conjugated)
  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
`ifdef CMUL_CONJ_EN
    wi_eff = bus.in_wi ^ {bus.in_conj, {(DW-1){1'b0}}};
`else
    wi_eff = bus.in_wi;
`endif
  end

  // A returning result is taken only while collecting and only until four have arrived
  always_comb begin
    capture = bus.mul_res_vld && !ret_cnt[2] && (state == ISSUE || state == DRAIN);
  end

  // Sequencer FSM with registered outputs and result collection
  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the result registers are reset too, because their values are visible on out_* after reset.
      state     <= IDLE;
      issue_cnt <= 2'd0;
      ret_cnt   <= 3'd0;
      ar_q      <= '0;
      ai_q      <= '0;
      wr_q      <= '0;
      wi_q      <= '0;
      in_rdy_q  <= 1'b1;
      mul_vld_q <= 1'b0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      rr_q      <= '0;
      ii_q      <= '0;
      ri_q      <= '0;
      ir_q      <= '0;
      exc_q     <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      if (capture) begin
        case (ret_cnt[1:0])
          2'd0:    rr_q <= bus.mul_res;
          2'd1:    ii_q <= bus.mul_res;
          2'd2:    ri_q <= bus.mul_res;
          default: ir_q <= bus.mul_res;
        endcase
        exc_q   <= exc_q | bus.mul_exception;
        ovf_q   <= ovf_q | bus.mul_overflow;
        unf_q   <= unf_q | bus.mul_underflow;
        ret_cnt <= ret_cnt + 3'd1;
      end

      case (state)
        IDLE: begin
          if (bus.in_vld) begin
            ar_q      <= bus.in_ar;
            ai_q      <= bus.in_ai;
            wr_q      <= bus.in_wr;
            wi_q      <= wi_eff;
            exc_q     <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            ret_cnt   <= 3'd0;
            issue_cnt <= 2'd0;
            // Pair 0 goes out directly from the inputs so issue starts next cycle
            mul_a_q   <= bus.in_ar;
            mul_b_q   <= bus.in_wr;
            mul_vld_q <= 1'b1;
            in_rdy_q  <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_cnt == 2'd3) begin
            mul_vld_q <= 1'b0;
            state     <= DRAIN;
          end else begin
            issue_cnt <= issue_cnt + 2'd1;
            case (issue_cnt)
              2'd0: begin mul_a_q <= ai_q; mul_b_q <= wi_q; end
              2'd1: begin mul_a_q <= ar_q; mul_b_q <= wi_q; end
              default: begin mul_a_q <= ai_q; mul_b_q <= wr_q; end
            endcase
          end
        end
        DRAIN: begin
          if (ret_cnt[2] || (capture && ret_cnt[1:0] == 2'd3)) begin
            out_vld_q <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_rdy) begin
            out_vld_q <= 1'b0;
            in_rdy_q  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_rdy  = in_rdy_q;
  assign bus.mul_vld = mul_vld_q;
  assign bus.mul_a   = mul_a_q;
  assign bus.mul_b   = mul_b_q;
  assign bus.out_rr  = rr_q;
  assign bus.out_ii  = ii_q;
  assign bus.out_ri  = ri_q;
  assign bus.out_ir  = ir_q;
  assign bus.out_exc = exc_q;
  assign bus.out_ovf = ovf_q;
  assign bus.out_unf = unf_q;
  assign bus.out_vld = out_vld_q;

endmodule

// File: tb/tb_cmul_mul_sequencer.sv
// Testbench for cmul_mul_sequencer.
// A simplified FP16 multiplier model with selectable latency sits on the
// multiplier port. Expected results come from a reference that applies the
// same multiplier function to the four operand pairings of a complex product.
module tb_cmul_mul_sequencer;

  typedef struct packed {
    logic [15:0] rr, ii, ri, ir;
    logic        exc, ovf, unf;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   lat = 1;
  logic stray = 1'b0;
  logic conj_sel = 1'b0;

  cmul_mul_sequencer_if #(.DW(16)) bus ();

  cmul_mul_sequencer #(.DW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef CMUL_CONJ_EN
  assign bus.in_conj = conj_sel;
`endif

  // Simplified FP16 multiply returning {exc, ovf, unf, result}
  function automatic logic [18:0] fmul(input logic [15:0] a, input logic [15:0] b);
    logic        s;
    logic [10:0] ma, mb;
    logic [21:0] p;
    logic [9:0]  m;
    int          e;
    s = a[15] ^ b[15];
    if (a[14:10] == 5'h1f || b[14:10] == 5'h1f) return {3'b100, 16'h7e00};
    if (a[14:10] == 5'h00 || b[14:10] == 5'h00) return {3'b000, s, 15'h0};
    ma = {1'b1, a[9:0]};
    mb = {1'b1, b[9:0]};
    p  = 22'(ma) * 22'(mb);
    e  = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) begin m = p[20:11]; e = e + 1; end
    else       m = p[19:10];
    if (e >= 31) return {3'b010, s, 5'h1f, 10'h0};
    if (e <= 0)  return {3'b001, s, 15'h0};
    return {3'b000, s, e[4:0], m};
  endfunction

  // Reference: four real products of (ar + j ai)(wr + j wi), optionally conjugated twiddle
  function automatic res_t model(input logic [15:0] ar, ai, wr, wi, input logic conj);
    logic [15:0] w_i;
    logic [18:0] p_rr, p_ii, p_ri, p_ir;
    res_t r;
    w_i  = conj ? {~wi[15], wi[14:0]} : wi;
    p_rr = fmul(ar, wr);
    p_ii = fmul(ai, w_i);
    p_ri = fmul(ar, w_i);
    p_ir = fmul(ai, wr);
    r.rr  = p_rr[15:0];
    r.ii  = p_ii[15:0];
    r.ri  = p_ri[15:0];
    r.ir  = p_ir[15:0];
    r.exc = p_rr[18] | p_ii[18] | p_ri[18] | p_ir[18];
    r.ovf = p_rr[17] | p_ii[17] | p_ri[17] | p_ir[17];
    r.unf = p_rr[16] | p_ii[16] | p_ri[16] | p_ir[16];
    return r;
  endfunction

  // Multiplier model: registered pipeline, result taken from stage lat-1
  bit          p_v [4];
  logic [18:0] p_d [4];
  always @(posedge clk) begin
    p_v[0] <= bus.mul_vld;
    p_d[0] <= fmul(bus.mul_a, bus.mul_b);
    for (int k = 1; k < 4; k++) begin
      p_v[k] <= p_v[k-1];
      p_d[k] <= p_d[k-1];
    end
  end
  assign bus.mul_res_vld = p_v[lat-1] | stray;
  assign {bus.mul_exception, bus.mul_overflow, bus.mul_underflow, bus.mul_res} = p_d[lat-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present an operand set and wait (bounded) for its accept; returns the accept cycle
  task automatic send(input logic [15:0] ar, ai, wr, wi, output int acc);
    bus.in_ar  = ar;
    bus.in_ai  = ai;
    bus.in_wr  = wr;
    bus.in_wi  = wi;
    bus.in_vld = 1'b1;
    acc = -1;
    for (int i = 0; i < 60; i++) begin
      if (bus.in_rdy === 1'b1) begin
        @(posedge clk);
        #1 acc = cyc;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    check("accept_seen", 32'(acc >= 0), 32'd1);
  endtask

  // Wait for results of an accepted set, check them, apply stall cycles of backpressure
  task automatic collect(input logic [15:0] ar, ai, wr, wi, input logic conj,
                         input int acc, input int stall);
    res_t exp;
    int   nmul;
    bit   found;
    exp   = model(ar, ai, wr, wi, conj);
    nmul  = 0;
    found = 1'b0;
    bus.out_rdy = (stall == 0);
    for (int i = 0; i < 60; i++) begin
      if (bus.mul_vld === 1'b1) nmul++;
      if (bus.out_vld === 1'b1) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("out_vld_seen", 32'(found), 32'd1);
    check("out_vld_latency", 32'(cyc - acc), 32'(4 + lat));
    check("mul_vld_cycles", 32'(nmul), 32'd4);
    check("mul_a_hold", 32'(bus.mul_a), 32'(ai));
    check("mul_b_hold", 32'(bus.mul_b), 32'(wr));
    check("out_rr", 32'(bus.out_rr), 32'(exp.rr));
    check("out_ii", 32'(bus.out_ii), 32'(exp.ii));
    check("out_ri", 32'(bus.out_ri), 32'(exp.ri));
    check("out_ir", 32'(bus.out_ir), 32'(exp.ir));
    check("out_flags", 32'({bus.out_exc, bus.out_ovf, bus.out_unf}),
          32'({exp.exc, exp.ovf, exp.unf}));
    for (int s = 0; s < stall; s++) begin
      stray = (s == 0);
      @(negedge clk);
      stray = 1'b0;
      check("stall_out_vld", 32'(bus.out_vld), 32'd1);
      check("stall_in_rdy", 32'(bus.in_rdy), 32'd0);
      check("stall_data", 32'({bus.out_rr, bus.out_ir}), 32'({exp.rr, exp.ir}));
      check("stall_data2", 32'({bus.out_ii, bus.out_ri}), 32'({exp.ii, exp.ri}));
      check("stall_flags", 32'({bus.out_exc, bus.out_ovf, bus.out_unf}),
            32'({exp.exc, exp.ovf, exp.unf}));
    end
    bus.out_rdy = 1'b1;
    @(negedge clk);
    check("post_hs_out_vld", 32'(bus.out_vld), 32'd0);
    check("post_hs_in_rdy", 32'(bus.in_rdy), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int a0, a1, a2, seen, stall;
    logic [15:0] ar, ai, wr, wi, br, bi, vr, vi;
    logic c;

    rst = 1'b1;
    bus.in_vld = 1'b0;
    bus.in_ar = '0; bus.in_ai = '0; bus.in_wr = '0; bus.in_wi = '0;
    bus.out_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Reset values
    check("rst_in_rdy", 32'(bus.in_rdy), 32'd1);
    check("rst_mul_vld", 32'(bus.mul_vld), 32'd0);
    check("rst_mul_ab", 32'({bus.mul_a, bus.mul_b}), 32'd0);
    check("rst_out_vld", 32'(bus.out_vld), 32'd0);
    check("rst_out_data", 32'({bus.out_rr, bus.out_ii}), 32'd0);
    check("rst_out_data2", 32'({bus.out_ri, bus.out_ir}), 32'd0);
    check("rst_flags", 32'({bus.out_exc, bus.out_ovf, bus.out_unf}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic product
    send(16'h4000, 16'h3c00, 16'h3800, 16'hbc00, a0);
    bus.in_vld = 1'b0;
    collect(16'h4000, 16'h3c00, 16'h3800, 16'hbc00, 1'b0, a0, 0);
    check("basic_rr_const", 32'(bus.out_rr), 32'h3c00);
    check("basic_ri_const", 32'(bus.out_ri), 32'hc000);

`ifdef CMUL_CONJ_EN
    // Conjugated twiddle
    conj_sel = 1'b1;
    send(16'h4000, 16'h3c00, 16'h3800, 16'hbc00, a0);
    bus.in_vld = 1'b0;
    collect(16'h4000, 16'h3c00, 16'h3800, 16'hbc00, 1'b1, a0, 0);
    check("conj_ii_const", 32'(bus.out_ii), 32'h3c00);
    check("conj_ri_const", 32'(bus.out_ri), 32'h4000);
    conj_sel = 1'b0;
`endif

    // Overflow
    send(16'h7800, 16'h3c00, 16'h7800, 16'h3c00, a0);
    bus.in_vld = 1'b0;
    collect(16'h7800, 16'h3c00, 16'h7800, 16'h3c00, 1'b0, a0, 0);
    check("ovf_rr_const", 32'(bus.out_rr), 32'h7c00);
    check("ovf_flag_const", 32'(bus.out_ovf), 32'd1);

    // Backpressure: next set held on in_vld while out_rdy is low for 3 cycles
    send(16'h4200, 16'hc000, 16'h3a00, 16'h3400, a0);
    bus.in_ar = 16'h3c00; bus.in_ai = 16'h4400; bus.in_wr = 16'hb800; bus.in_wi = 16'h4000;
    collect(16'h4200, 16'hc000, 16'h3a00, 16'h3400, 1'b0, a0, 3);
    send(16'h3c00, 16'h4400, 16'hb800, 16'h4000, a1);
    bus.in_vld = 1'b0;
    check("bp_accept_gap", 32'(a1 - a0), 32'd10);
    collect(16'h3c00, 16'h4400, 16'hb800, 16'h4000, 1'b0, a1, 0);

    // Reset during the second ISSUE cycle
    send(16'h4000, 16'h4000, 16'h4000, 16'h4000, a0);
    bus.in_vld = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_mul_vld", 32'(bus.mul_vld), 32'd0);
    check("mid_rst_in_rdy", 32'(bus.in_rdy), 32'd1);
    check("mid_rst_out_rr", 32'(bus.out_rr), 32'd0);
    rst = 1'b0;
    stray = 1'b1;
    @(negedge clk);
    @(negedge clk);
    stray = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_vld === 1'b1) seen++;
      @(negedge clk);
    end
    check("mid_rst_no_out_vld", 32'(seen), 32'd0);
    check("stray_ignored_rr", 32'(bus.out_rr), 32'd0);
    send(16'h3e00, 16'hbe00, 16'h4100, 16'h3b00, a0);
    bus.in_vld = 1'b0;
    collect(16'h3e00, 16'hbe00, 16'h4100, 16'h3b00, 1'b0, a0, 0);

    // Back-to-back: in_vld held, three random sets, out_rdy high
    ar = 16'($urandom); ai = 16'($urandom); wr = 16'($urandom); wi = 16'($urandom);
    br = 16'($urandom); bi = 16'($urandom); vr = 16'($urandom); vi = 16'($urandom);
    send(ar, ai, wr, wi, a0);
    bus.in_ar = br; bus.in_ai = bi; bus.in_wr = vr; bus.in_wi = vi;
    collect(ar, ai, wr, wi, 1'b0, a0, 0);
    send(br, bi, vr, vi, a1);
    check("b2b_gap_1", 32'(a1 - a0), 32'd7);
    bus.in_ar = ai; bus.in_ai = ar; bus.in_wr = wi; bus.in_wi = wr;
    collect(br, bi, vr, vi, 1'b0, a1, 0);
    send(ai, ar, wi, wr, a2);
    check("b2b_gap_2", 32'(a2 - a1), 32'd7);
    bus.in_vld = 1'b0;
    collect(ai, ar, wi, wr, 1'b0, a2, 0);

    // Random operand sets with varying multiplier latency and backpressure
    for (int n = 0; n < 20; n++) begin
      ar = 16'($urandom); ai = 16'($urandom); wr = 16'($urandom); wi = 16'($urandom);
`ifdef CMUL_CONJ_EN
      c = 1'($urandom);
`else
      c = 1'b0;
`endif
      conj_sel = c;
      lat   = int'($urandom_range(1, 3));
      stall = int'($urandom_range(0, 2));
      send(ar, ai, wr, wi, a0);
      bus.in_vld = 1'b0;
      collect(ar, ai, wr, wi, c, a0, stall);
    end
    lat = 1;
    conj_sel = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
